id_branch_ctrl: RTL and testbench

//  Sequences the ID-stage branch comparator for conditional branches. Decodes funct3 into the

---
 rtl/id_branch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_id_branch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_branch_ctrl.sv
// ---------------------------------------------------------------------------
// id_branch_ctrl
// ID-stage sequencer for conditional branches. Drives the comparator op code,
// holds PC and IF/ID while forwarded operands are pending, samples the
// comparator zero flag and issues a one-cycle redirect (PC select plus IF
// flush) when the branch is taken.
//
// Optional feature: define BRANCH_STATS_EN to enable the stat_br, stat_taken
// and stat_stall event counters. When it is undefined, the three ports remain
// and are tied to zero.
// ---------------------------------------------------------------------------
module id_branch_ctrl #(
   parameter int WAIT_LIMIT = 4,   // max consecutive WAIT cycles (1..15)
   parameter int CNT_W      = 4    // wait counter width, must hold WAIT_LIMIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   input  logic [2:0]  br_funct3,
   input  logic        opnd_ready,
   input  logic        cmp_zero,
   output logic [4:0]  cmp_op,
   output logic        stall_if_id,
   output logic        pc_sel_branch,
   output logic        flush_if,
   output logic        br_done,
   output logic        br_taken,
   output logic        br_illegal,
   output logic        br_timeout,
   output logic [31:0] stat_br,
   output logic [31:0] stat_taken,
   output logic [31:0] stat_stall
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESOLVE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   wait_cnt;
   logic               taken_q;
   logic               illegal_q;
   logic               take;
   logic               reserved;

   // Comparator op code decoded from funct3; quiet when no branch is in ID.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cmp_op = 5'b00000;
      if (br_valid) begin
         case (br_funct3)
            3'b000, 3'b001: cmp_op = 5'b00011;
            3'b100:         cmp_op = 5'b00101;
            3'b101:         cmp_op = 5'b01010;
            3'b110:         cmp_op = 5'b00110;
            3'b111:         cmp_op = 5'b01011;
            default:        cmp_op = 5'b00000;
         endcase
      end
   end

   // Branch outcome from the zero flag; only BNE inverts it, reserved funct3 never takes.
   always_comb begin
      reserved = (br_funct3 == 3'b010) || (br_funct3 == 3'b011);
      take     = 1'b0;
      if (!reserved) begin
         take = (br_funct3 == 3'b001) ? ~cmp_zero : cmp_zero;
      end
   end

   // Hold PC and IF/ID while a branch is accepted but not yet resolved.
   always_comb begin
      stall_if_id = (state == S_WAIT) || ((state == S_IDLE) && br_valid);
   end

   // Branch sequencing FSM with registered resolve outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         taken_q    <= 1'b0;
         illegal_q  <= 1'b0;
         br_done    <= 1'b0;
         br_timeout <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         br_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (br_valid) begin
                  if (opnd_ready) begin
                     taken_q   <= take;
                     illegal_q <= reserved;
                     br_done   <= 1'b1;
                     state     <= S_RESOLVE;
                  end else begin
                     wait_cnt <= CNT_W'(1);
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!br_valid) begin
                  // Upstream killed the branch: abandon it silently.
                  wait_cnt <= '0;
                  state    <= S_IDLE;
               end else if (opnd_ready) begin
                  taken_q   <= take;
                  illegal_q <= reserved;
                  br_done   <= 1'b1;
                  state     <= S_RESOLVE;
               end else if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
                  // Operands never arrived: resolve not-taken and flag it.
                  taken_q    <= 1'b0;
                  illegal_q  <= 1'b0;
                  br_timeout <= 1'b1;
                  br_done    <= 1'b1;
                  state      <= S_RESOLVE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_RESOLVE: begin
               // br_valid here belongs to the branch now leaving ID.
               taken_q   <= 1'b0;
               illegal_q <= 1'b0;
               wait_cnt  <= '0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign br_taken      = taken_q;
   assign pc_sel_branch = taken_q;
   assign flush_if      = taken_q;
   assign br_illegal    = illegal_q;

`ifdef BRANCH_STATS_EN
   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_br    <= 32'h0;
         stat_taken <= 32'h0;
         stat_stall <= 32'h0;
      end else begin
         if (br_done) begin
            stat_br <= stat_br + 32'd1;
         end
         if (br_done && taken_q) begin
            stat_taken <= stat_taken + 32'd1;
         end
         if (stall_if_id) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`else
   assign stat_br    = 32'h0;
   assign stat_taken = 32'h0;
   assign stat_stall = 32'h0;
`endif

endmodule

// File: tb/tb_id_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_id_branch_ctrl
// Self-checking bench for id_branch_ctrl. Each branch is described by its
// funct3, zero flag, operand delay and optional kill cycle; expected stall
// length, outcome and flags are computed arithmetically from those values.
// Honours BRANCH_STATS_EN for the statistics ports.
// ---------------------------------------------------------------------------
module tb_id_branch_ctrl;

   localparam int WAIT_LIMIT = 4;
   localparam logic [4:0] OP_TBL [8] = '{5'b00011, 5'b00011, 5'b00000, 5'b00000,
                                         5'b00101, 5'b01010, 5'b00110, 5'b01011};

   logic        clk = 1'b0;
   logic        rst;
   logic        br_valid;
   logic [2:0]  br_funct3;
   logic        opnd_ready;
   logic        cmp_zero;
   logic [4:0]  cmp_op;
   logic        stall_if_id;
   logic        pc_sel_branch;
   logic        flush_if;
   logic        br_done;
   logic        br_taken;
   logic        br_illegal;
   logic        br_timeout;
   logic [31:0] stat_br;
   logic [31:0] stat_taken;
   logic [31:0] stat_stall;

   int   checks = 0;
   int   errors = 0;
   logic exp_timeout;
   int   m_br, m_taken, m_stall;

   id_branch_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .br_valid      (br_valid),
      .br_funct3     (br_funct3),
      .opnd_ready    (opnd_ready),
      .cmp_zero      (cmp_zero),
      .cmp_op        (cmp_op),
      .stall_if_id   (stall_if_id),
      .pc_sel_branch (pc_sel_branch),
      .flush_if      (flush_if),
      .br_done       (br_done),
      .br_taken      (br_taken),
      .br_illegal    (br_illegal),
      .br_timeout    (br_timeout),
      .stat_br       (stat_br),
      .stat_taken    (stat_taken),
      .stat_stall    (stat_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [4:0] ref_op(input logic v, input logic [2:0] f3);
      return v ? OP_TBL[f3] : 5'b00000;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Assert reset from a drive point and check the cleared outputs.
   task automatic apply_reset(input string tag);
      rst        = 1'b1;
      br_valid   = 1'b0;
      opnd_ready = 1'b0;
      exp_timeout = 1'b0;
      m_br = 0; m_taken = 0; m_stall = 0;
      @(negedge clk);
      checks++;
      if ({stall_if_id, br_done, br_taken, pc_sel_branch, flush_if, br_illegal, br_timeout} !== 7'b0) begin
         errors++;
         $display("FAIL %s outputs got stall=%b done=%b taken=%b pcsel=%b flush=%b ill=%b to=%b want all 0",
                  tag, stall_if_id, br_done, br_taken, pc_sel_branch, flush_if, br_illegal, br_timeout);
      end
      checks++;
      if ((stat_br | stat_taken | stat_stall) !== 32'h0) begin
         errors++;
         $display("FAIL %s stats got %0d/%0d/%0d want 0/0/0", tag, stat_br, stat_taken, stat_stall);
      end
      next_cycle();
      rst = 1'b0;
   endtask

   // Cycles with no branch in ID.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         br_valid   = 1'b0;
         br_funct3  = 3'($urandom);
         opnd_ready = 1'($urandom);
         cmp_zero   = 1'($urandom);
         @(negedge clk);
         checks++;
         if ({stall_if_id, br_done, pc_sel_branch, flush_if} !== 4'b0 || cmp_op !== 5'b0
             || br_timeout !== exp_timeout) begin
            errors++;
            $display("FAIL idle got stall=%b done=%b pcsel=%b flush=%b op=%b to=%b want 0 0 0 0 00000 %b",
                     stall_if_id, br_done, pc_sel_branch, flush_if, cmp_op, br_timeout, exp_timeout);
         end
         next_cycle();
      end
   endtask

   // Drive one branch: operands arrive d cycles after it enters ID (d=0 means
   // immediately); kill_at>=0 drops br_valid at that cycle index instead.
   task automatic run_branch(input logic [2:0] f3, input logic z, input int d, input int kill_at);
      int   n_stall;
      logic to, rsv, exp_t, exp_ill, v;
      to      = (kill_at < 0) && (d > WAIT_LIMIT);
      n_stall = (kill_at >= 0) ? kill_at + 1 : (to ? WAIT_LIMIT + 1 : d + 1);
      rsv     = (f3 == 3'd2) || (f3 == 3'd3);
      exp_t   = to ? 1'b0 : (rsv ? 1'b0 : ((f3 == 3'd1) ? ~z : z));
      exp_ill = !to && rsv;
      for (int i = 0; i < n_stall; i++) begin
         v          = (i != kill_at);
         br_valid   = v;
         br_funct3  = f3;
         cmp_zero   = z;
         opnd_ready = v ? (i >= d) : 1'($urandom);
         @(negedge clk);
         checks++;
         if (stall_if_id !== 1'b1 || br_done !== 1'b0 || pc_sel_branch !== 1'b0 || flush_if !== 1'b0
             || br_timeout !== exp_timeout || cmp_op !== ref_op(v, f3)) begin
            errors++;
            $display("FAIL hold f3=%0d d=%0d i=%0d got stall=%b done=%b pcsel=%b flush=%b to=%b op=%b want 1 0 0 0 %b %b",
                     f3, d, i, stall_if_id, br_done, pc_sel_branch, flush_if, br_timeout, cmp_op,
                     exp_timeout, ref_op(v, f3));
         end
         next_cycle();
         m_stall++;
      end
      if (kill_at >= 0) begin
         idle(1);
         return;
      end
      if (to) exp_timeout = 1'b1;
      v          = 1'($urandom);
      br_valid   = v;
      opnd_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (stall_if_id !== 1'b0 || br_done !== 1'b1 || br_taken !== exp_t || pc_sel_branch !== exp_t
          || flush_if !== exp_t || br_illegal !== exp_ill || br_timeout !== exp_timeout
          || cmp_op !== ref_op(v, f3)) begin
         errors++;
         $display("FAIL resolve f3=%0d z=%b d=%0d got stall=%b done=%b tk=%b pcsel=%b flush=%b ill=%b to=%b op=%b want 0 1 %b %b %b %b %b %b",
                  f3, z, d, stall_if_id, br_done, br_taken, pc_sel_branch, flush_if, br_illegal,
                  br_timeout, cmp_op, exp_t, exp_t, exp_t, exp_ill, exp_timeout, ref_op(v, f3));
      end
      next_cycle();
      m_br++;
      if (exp_t) m_taken++;
   endtask

   task automatic check_stats(input string tag, input int e_br, input int e_tk, input int e_st);
`ifdef BRANCH_STATS_EN
      checks++;
      if (stat_br !== 32'(e_br) || stat_taken !== 32'(e_tk) || stat_stall !== 32'(e_st)) begin
         errors++;
         $display("FAIL %s stats got %0d/%0d/%0d want %0d/%0d/%0d",
                  tag, stat_br, stat_taken, stat_stall, e_br, e_tk, e_st);
      end
`else
      checks++;
      if ((stat_br | stat_taken | stat_stall) !== 32'h0) begin
         errors++;
         $display("FAIL %s stats got %0d/%0d/%0d want tied 0", tag, stat_br, stat_taken, stat_stall);
      end
`endif
   endtask

   task automatic test_reset();
      apply_reset("reset_state");
      idle(2);
   endtask

   task automatic test_beq_bne();
      apply_reset("reset_stats");
      run_branch(3'b000, 1'b1, 0, -1);
      run_branch(3'b001, 1'b1, 0, -1);
      idle(1);
      check_stats("beq_bne", 2, 1, 2);
   endtask

   task automatic test_wait();
      run_branch(3'b110, 1'b1, 2, -1);
      run_branch(3'b100, 1'b0, 1, -1);
      run_branch(3'b111, 1'b1, WAIT_LIMIT, -1);
      idle(1);
   endtask

   task automatic test_timeout();
      run_branch(3'b110, 1'b1, WAIT_LIMIT + 3, -1);
      idle(2);
      run_branch(3'b000, 1'b1, 0, -1);
      run_branch(3'b101, 1'b1, 1, -1);
      idle(1);
   endtask

   task automatic test_illegal();
      run_branch(3'b010, 1'b1, 0, -1);
      run_branch(3'b011, 1'b0, 1, -1);
      idle(1);
   endtask

   task automatic test_kill();
      run_branch(3'b101, 1'b1, 5, 2);
      run_branch(3'b101, 1'b1, 9, WAIT_LIMIT);
      idle(2);
   endtask

   task automatic test_rst_mid_wait();
      br_valid = 1'b1; br_funct3 = 3'b110; cmp_zero = 1'b1; opnd_ready = 1'b0;
      next_cycle();
      next_cycle();
      apply_reset("rst_in_wait");
      idle(2);
      br_valid = 1'b1; br_funct3 = 3'b000; cmp_zero = 1'b1; opnd_ready = 1'b1;
      next_cycle();
      apply_reset("rst_in_resolve");
      idle(2);
   endtask

   task automatic test_back_to_back();
      apply_reset("reset_random");
      for (int n = 0; n < 60; n++) begin
         logic [2:0] f3;
         int d, k, kmax;
         f3 = 3'($urandom);
         d  = $urandom_range(0, WAIT_LIMIT + 2);
         k  = -1;
         if (d >= 2 && $urandom_range(0, 5) == 0) begin
            kmax = (d - 1 < WAIT_LIMIT) ? d - 1 : WAIT_LIMIT;
            k    = $urandom_range(1, kmax);
         end
         run_branch(f3, 1'($urandom), d, k);
         idle($urandom_range(0, 2));
      end
      idle(1);
      check_stats("random", m_br, m_taken, m_stall);
   endtask

   initial begin
      rst = 1'b1; br_valid = 1'b0; br_funct3 = 3'b000; opnd_ready = 1'b0; cmp_zero = 1'b0;
      exp_timeout = 1'b0; m_br = 0; m_taken = 0; m_stall = 0;
      test_reset();
      test_beq_bne();
      test_wait();
      test_timeout();
      test_illegal();
      test_kill();
      test_rst_mid_wait();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
